// File: rtl/branch_resolve.sv
// Branch/jump resolution: computes the architectural next PC, flags mispredicts,
// trains a 2-bit BHT and keeps resolved/mispredict statistics.
package branch_resolve_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_ALU, OP_LOAD, OP_STORE,
    OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU
  } op_t;

  typedef struct packed {
    op_t op;
  } contral_t;
endpackage

module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      raw_instr,
  input  contral_t         ctl,
  input  logic             cmp,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  jumppc,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic [XLEN-1:0]  query_pc,
  output logic             query_taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);
  localparam int IDX = $clog2(BHT_DEPTH);

  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mis_count_q, mis_count_d;
  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_d [BHT_DEPTH];

  logic [XLEN-1:0]  imm_b, imm_j, actual_pc;
  logic [IDX-1:0]   upd_idx;
  logic             is_ctrl, is_br, taken, accept, mispredict;
  logic             unused_bits;

  assign unused_bits = ^{raw_instr[6:0], jumppc[0], query_pc[XLEN-1:IDX+2], query_pc[1:0]};

  assign in_ready       = !redirect_valid_q || redirect_ready;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign br_count       = br_count_q;
  assign mis_count      = mis_count_q;
  // Reads the registered table, so a same-cycle update is not visible yet.
  assign query_taken    = bht_q[query_pc[IDX+1:2]][1];

  always_comb begin
    imm_b = {{(XLEN-13){raw_instr[31]}}, raw_instr[31], raw_instr[7],
             raw_instr[30:25], raw_instr[11:8], 1'b0};
    imm_j = {{(XLEN-21){raw_instr[31]}}, raw_instr[31], raw_instr[19:12],
             raw_instr[20], raw_instr[30:21], 1'b0};
    is_ctrl   = 1'b0;
    is_br     = 1'b0;
    taken     = 1'b0;
    actual_pc = pc + XLEN'(4);
    case (ctl.op)
      OP_JAL:  begin is_ctrl = 1'b1; taken = 1'b1; actual_pc = pc + imm_j; end
      OP_JALR: begin is_ctrl = 1'b1; taken = 1'b1; actual_pc = {jumppc[XLEN-1:1], 1'b0}; end
      OP_BEQ, OP_BLT, OP_BLTU: begin is_ctrl = 1'b1; is_br = 1'b1; taken = cmp;  end
      OP_BNE, OP_BGE, OP_BGEU: begin is_ctrl = 1'b1; is_br = 1'b1; taken = !cmp; end
      default: ;
    endcase
    if (is_br && taken) actual_pc = pc + imm_b;

    accept     = in_valid && in_ready;
    mispredict = is_ctrl && (actual_pc != pred_pc);
    upd_idx    = pc[IDX+1:2];

    bht_d = bht_q;
    if (accept && is_br) begin
      if (taken && bht_q[upd_idx] != 2'd3)
        bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
      else if (!taken && bht_q[upd_idx] != 2'd0)
        bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
    end

    br_count_d  = br_count_q + CNT_W'(accept && is_ctrl);
    mis_count_d = mis_count_q + CNT_W'(accept && mispredict);

    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    if (accept && mispredict) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = actual_pc;
    end else if (redirect_ready) begin
      redirect_valid_d = 1'b0;
      redirect_pc_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      br_count_q       <= '0;
      mis_count_q      <= '0;
      for (int unsigned i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'd1;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      br_count_q       <= br_count_d;
      mis_count_q      <= mis_count_d;
      bht_q            <= bht_d;
    end
  end
endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus random traffic
// against a behavioural model of next-PC, redirect, BHT and statistics.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int XLEN  = 64;
  localparam int DEPTH = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      raw_instr;
  contral_t         ctl;
  logic             cmp;
  logic [XLEN-1:0]  pc, jumppc, pred_pc, query_pc;
  logic             redirect_valid, redirect_ready;
  logic [XLEN-1:0]  redirect_pc;
  logic             query_taken;
  logic [CNT_W-1:0] br_count, mis_count;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  bit          m_rv;
  logic [63:0] m_rpc;
  int unsigned m_br, m_mis;
  int          m_bht [DEPTH];

  branch_resolve #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .raw_instr(raw_instr), .ctl(ctl), .cmp(cmp), .pc(pc), .jumppc(jumppc),
    .pred_pc(pred_pc), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .query_pc(query_pc), .query_taken(query_taken),
    .br_count(br_count), .mis_count(mis_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_j(input int imm);
    int unsigned r;
    r = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) |
        (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) | 32'h6f;
    return r;
  endfunction

  function automatic logic [31:0] enc_b(input int imm);
    int unsigned r;
    r = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) |
        (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
    return r;
  endfunction

  function automatic bit m_is_ctrl(input op_t op);
    return op inside {OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  endfunction

  function automatic bit m_is_br(input op_t op);
    return m_is_ctrl(op) && !(op inside {OP_JAL, OP_JALR});
  endfunction

  function automatic bit m_taken(input op_t op, input bit c);
    if (op inside {OP_JAL, OP_JALR}) return 1'b1;
    if (op inside {OP_BEQ, OP_BLT, OP_BLTU}) return c;
    return !c;
  endfunction

  function automatic longint unsigned m_next(input op_t op, input int unsigned r,
      input bit c, input longint unsigned p, input longint unsigned jp);
    longint signed off;
    if (op == OP_JAL) begin
      off = (((r >> 31) & 1) << 20) | (((r >> 12) & 255) << 12) |
            (((r >> 20) & 1) << 11) | (((r >> 21) & 1023) << 1);
      if (off >= (1 << 20)) off -= (1 << 21);
      return p + longint'(off);
    end
    if (op == OP_JALR) return jp - (jp % 2);
    if (m_taken(op, c)) begin
      off = (((r >> 31) & 1) << 12) | (((r >> 7) & 1) << 11) |
            (((r >> 25) & 63) << 5) | (((r >> 8) & 15) << 1);
      if (off >= 4096) off -= 8192;
      return p + longint'(off);
    end
    return p + 4;
  endfunction

  task automatic model_reset();
    m_rv = 0; m_rpc = '0; m_br = 0; m_mis = 0;
    for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
  endtask

  // Called at the rising edge, with inputs still holding their pre-edge values.
  task automatic model_update();
    bit acc, mis;
    longint unsigned nxt;
    int idx;
    acc = in_valid && (!m_rv || redirect_ready);
    mis = 0;
    nxt = m_next(ctl.op, raw_instr, cmp, pc, jumppc);
    if (acc && m_is_ctrl(ctl.op)) begin
      m_br++;
      mis = (nxt != pred_pc);
      if (mis) m_mis++;
      if (m_is_br(ctl.op)) begin
        idx = int'((pc / 4) % DEPTH);
        if (m_taken(ctl.op, cmp)) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
        else                      m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
      end
    end
    if (mis) begin
      m_rv = 1; m_rpc = nxt;
    end else if (redirect_ready) begin
      m_rv = 0; m_rpc = '0;
    end
  endtask

  task automatic set_in(input op_t op, input logic [31:0] instr, input bit c,
      input logic [63:0] p, input logic [63:0] jp, input logic [63:0] pp,
      input bit v, input bit rr);
    ctl.op = op; raw_instr = instr; cmp = c; pc = p; jumppc = jp;
    pred_pc = pp; in_valid = v; redirect_ready = rr; query_pc = p;
  endtask

  // Entered at a falling edge with inputs already driven.
  task automatic step();
    #1;
    check("in_ready", 64'(in_ready), 64'(!m_rv || redirect_ready));
    check("query_taken", 64'(query_taken), 64'(m_bht[int'((query_pc / 4) % DEPTH)] >= 2));
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("redirect_valid", 64'(redirect_valid), 64'(m_rv));
    check("redirect_pc", redirect_pc, m_rpc);
    check("br_count", 64'(br_count), 64'(m_br % (1 << CNT_W)));
    check("mis_count", 64'(mis_count), 64'(m_mis % (1 << CNT_W)));
  endtask

  task automatic do_reset();
    set_in(OP_NOP, '0, 0, '0, '0, '0, 0, 0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(OP_NOP, '0, 0, '0, '0, '0, 0, 0);
    model_reset();
    #3;
    check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    check("rst_redirect_pc", redirect_pc, 64'd0);
    check("rst_br_count", 64'(br_count), 64'd0);
    check("rst_mis_count", 64'(mis_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_query_taken", 64'(query_taken), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // JAL with J-imm +0x20 mispredicted as fall-through
    set_in(OP_JAL, enc_j(32'h20), 0, 64'h1000, '0, 64'h1004, 1, 0);
    step();
    check("jal_rv", 64'(redirect_valid), 64'd1);
    check("jal_rpc", redirect_pc, 64'h1020);
    check("jal_mis", 64'(mis_count), 64'd1);

    // BNE not taken, correctly predicted, trains counter down
    do_reset();
    set_in(OP_BNE, enc_b(32'h40), 1, 64'h2000, '0, 64'h2004, 1, 1);
    step();
    check("bne_rv", 64'(redirect_valid), 64'd0);
    check("bne_br", 64'(br_count), 64'd1);
    set_in(OP_NOP, '0, 0, 64'h2000, '0, '0, 0, 1);
    #1 check("bne_qt", 64'(query_taken), 64'd0);
    step();

    // three taken BEQs with negative offset saturate the counter
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(OP_BEQ, enc_b(-8), 1, 64'h2400, '0, 64'h23f8, 1, 1);
      step();
      check("beq_sat_qt", 64'(query_taken), 64'd1);
    end
    check("beq_sat_mis", 64'(mis_count), 64'd0);

    // JALR target has bit 0 masked
    do_reset();
    set_in(OP_JALR, '0, 0, 64'h3100, 64'h3001, 64'h3000, 1, 1);
    step();
    check("jalr_rv", 64'(redirect_valid), 64'd0);
    check("jalr_mis", 64'(mis_count), 64'd0);

    // backpressure: redirect held for three cycles, then reload on the ready cycle
    do_reset();
    set_in(OP_BEQ, enc_b(32'h10), 1, 64'h4000, '0, 64'h4004, 1, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      set_in(OP_JAL, enc_j(32'h100), 0, 64'h5000, '0, 64'h5004, 1, 0);
      #1 check("bp_in_ready", 64'(in_ready), 64'd0);
      step();
      check("bp_rpc", redirect_pc, 64'h4010);
    end
    set_in(OP_JAL, enc_j(32'h100), 0, 64'h5000, '0, 64'h5004, 1, 1);
    step();
    check("bp_reload_rpc", redirect_pc, 64'h5100);
    check("bp_br", 64'(br_count), 64'd2);

    // asynchronous reset with a redirect pending
    set_in(OP_NOP, '0, 0, '0, '0, '0, 0, 0);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("areset_rv", 64'(redirect_valid), 64'd0);
    check("areset_br", 64'(br_count), 64'd0);
    check("areset_mis", 64'(mis_count), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      query_pc = 64'(i * 4);
      #0.1 check("areset_qt", 64'(query_taken), 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    check("post_reset_rv", 64'(redirect_valid), 64'd0);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      op_t             op;
      logic [63:0]     p, jp, pp;
      logic [31:0]     ins;
      bit              c;
      op  = op_t'($urandom_range(0, 11));
      ins = $urandom;
      c   = $urandom_range(0, 1);
      p   = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 7) == 0) p = 64'hFFFF_FFFF_FFFF_FFFC;
      jp  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0, 1:    pp = m_next(op, ins, c, p, jp);
        2:       pp = p + 64'd4;
        default: pp = {$urandom, $urandom};
      endcase
      set_in(op, ins, c, p, jp, pp, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 0) query_pc = {$urandom, $urandom};
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter XLEN, default 64, datapath and PC width in bits.
REQ-002 Parameter BHT_DEPTH, default 16, number of 2-bit predictor counters; power of two, at least 2.
REQ-003 Parameter CNT_W, default 32, width of the statistics counters.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  a resolved instruction is presented this cycle.
REQ-007 in_ready  out  1  block accepts the presented instruction.
REQ-008 raw_instr  in  32  instruction bits, used for immediates.
REQ-009 ctl  in  contral_t  decoded control; only ctl.op is used.
REQ-010 cmp  in  1  comparator result: 1 = equal (BEQ/BNE) or less-than (BLT/BGE/BLTU/BGEU).
REQ-011 pc  in  XLEN  PC of the instruction.
REQ-012 jumppc  in  XLEN  JALR sum rs1+imm from the ALU.
REQ-013 pred_pc  in  XLEN  next PC that fetch actually used.
REQ-014 redirect_valid  out  1  flush-and-refetch request is pending.
REQ-015 redirect_ready  in  1  fetch accepts the redirect.
REQ-016 redirect_pc  out  XLEN  correct next PC.
REQ-017 query_pc  in  XLEN  fetch-side BHT lookup address.
REQ-018 query_taken  out  1  prediction for query_pc.
REQ-019 br_count, mis_count  out  CNT_W each  resolved-control-op count and mispredict count.

Function
REQ-020 Control ops are JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU; every other op is ignored (no redirect, no BHT update, no count).
REQ-021 An accept occurs when in_valid && in_ready; in_ready = !redirect_valid || redirect_ready.
REQ-022 B-immediate is {instr[31], instr[7], instr[30:25], instr[11:8], 0}; J-immediate is {instr[31], instr[19:12], instr[20], instr[30:21], 0}; both are sign-extended to XLEN.
REQ-023 Taken is: always for JAL/JALR; cmp for BEQ/BLT/BLTU; !cmp for BNE/BGE/BGEU.
REQ-024 Actual next PC is: pc+J-immediate for JAL; {jumppc[XLEN-1:1],0} for JALR; pc+B-immediate if taken, else pc+4, for branches. All additions are modulo 2^XLEN.
REQ-025 Mispredict is (actual next PC != pred_pc) on an accepted control op.
REQ-026 On an accepted mispredict, the next cycle shows redirect_valid=1 and redirect_pc=actual next PC; the latency is 1 cycle and is registered.
REQ-027 redirect_valid and redirect_pc hold stable until a cycle with redirect_ready=1, then clear on that edge unless a new mispredict is accepted in the same cycle, in which case they reload.
REQ-028 A new instruction is not accepted while a redirect is pending and redirect_ready=0.
REQ-029 BHT index is pc[IDX+1:2], where IDX = log2(BHT_DEPTH).
REQ-030 On an accepted conditional branch, the indexed counter increments if taken and decrements if not, saturating at 3 and 0.
REQ-031 JAL and JALR do not update the BHT.
REQ-032 query_taken = counter[query_pc[IDX+1:2]][1], read combinationally.
REQ-033 A same-cycle update to the queried index returns the pre-update value.
REQ-034 br_count increments on every accepted control op; mis_count increments on every accepted mispredict; both wrap from 2^CNT_W-1 to 0.

Reset
REQ-035 While reset=1, asynchronously: redirect_valid=0, redirect_pc=0, br_count=0, mis_count=0, and all BHT counters=1 (weakly not-taken, so query_taken=0).
REQ-036 Reset asserted with a redirect pending discards that redirect; no redirect is issued after reset deasserts.
REQ-037 in_ready=1 during and immediately after reset.

Verification
REQ-038 JAL at pc=0x1000 with J-imm +0x20, pred_pc=0x1004 -> next cycle redirect_valid=1, redirect_pc=0x1020, mis_count=1.
REQ-039 BNE at pc=0x2000, cmp=1, pred_pc=0x2004 -> no redirect, br_count=1; the BHT entry for 0x2000 goes 1->0 and query_taken=0.
REQ-040 Three taken BEQs at the same pc -> counter goes 1->2->3->3 (saturates) and query_taken=1 after the first update.
REQ-041 JALR with jumppc=0x3001 and pred_pc=0x3000 -> no mispredict, because the target is masked to 0x3000.
REQ-042 Mispredict with redirect_ready held 0 for 3 cycles -> in_ready=0 and redirect_pc stable for those cycles; the next accept is allowed in the ready cycle.
REQ-043 Reset pulse while redirect pending -> redirect_valid drops immediately, asynchronously; counters read 0 and query_taken=0 for all indices.
